// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a 4x4 systolic matrix-multiply job: clears the PE array, feeds operands,
// captures the 16 results into output memory and streams them out with a valid/ready handshake.
module systolic_seq_ctrl #(
    parameter int unsigned COMPUTE_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        pe_clear,
    output logic        feed_en,
    output logic [7:0]  feed_cycle,
    output logic        mem_w_en,
    output logic [4:0]  mem_read_addr,
    input  logic [15:0] mem_read_data,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COMPUTE,
        CAPTURE,
        DRAIN_ADDR,
        DRAIN_OUT,
        DONE
    } state_t;

    localparam logic [7:0] LAST_CYCLE = 8'(COMPUTE_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] idx;

    // The read memory is registered, so the word is only valid while out_valid is high.
    assign out_data = out_valid ? mem_read_data : '0;

    // Outputs are registered: each transition loads the values belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            pe_clear      <= 1'b0;
            feed_en       <= 1'b0;
            feed_cycle    <= '0;
            mem_w_en      <= 1'b0;
            mem_read_addr <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            pe_clear      <= 1'b0;
            feed_en       <= 1'b0;
            feed_cycle    <= '0;
            mem_w_en      <= 1'b0;
            mem_read_addr <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        pe_clear <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    state      <= COMPUTE;
                    cnt        <= '0;
                    feed_en    <= 1'b1;
                    feed_cycle <= '0;
                end
                COMPUTE: begin
                    if (cnt == LAST_CYCLE) begin
                        state    <= CAPTURE;
                        mem_w_en <= 1'b1;
                        idx      <= '0;
                    end else begin
                        cnt        <= cnt + 8'd1;
                        feed_en    <= 1'b1;
                        feed_cycle <= cnt + 8'd1;
                    end
                end
                CAPTURE: begin
                    state         <= DRAIN_ADDR;
                    mem_read_addr <= {1'b0, idx};
                end
                DRAIN_ADDR: begin
                    state         <= DRAIN_OUT;
                    mem_read_addr <= {1'b0, idx};
                    out_valid     <= 1'b1;
                    out_last      <= (idx == 4'd15);
                end
                DRAIN_OUT: begin
                    if (!out_ready) begin
                        mem_read_addr <= {1'b0, idx};
                        out_valid     <= 1'b1;
                        out_last      <= (idx == 4'd15);
                    end else if (idx == 4'd15) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state         <= DRAIN_ADDR;
                        idx           <= idx + 4'd1;
                        mem_read_addr <= {1'b0, idx + 4'd1};
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: cycle-accurate timeline checks plus a word scoreboard,
// run on a COMPUTE_CYCLES=10 instance and a COMPUTE_CYCLES=1 instance.
module tb_systolic_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst           [2];
    logic        start         [2];
    logic        out_ready     [2];
    logic        pe_clear      [2];
    logic        feed_en       [2];
    logic [7:0]  feed_cycle    [2];
    logic        mem_w_en      [2];
    logic [4:0]  mem_read_addr [2];
    logic [15:0] mem_read_data [2];
    logic        out_valid     [2];
    logic [15:0] out_data      [2];
    logic        out_last      [2];
    logic        busy          [2];
    logic        done          [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_t    = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.COMPUTE_CYCLES(10)) u_c10 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .pe_clear(pe_clear[0]), .feed_en(feed_en[0]),
        .feed_cycle(feed_cycle[0]), .mem_w_en(mem_w_en[0]), .mem_read_addr(mem_read_addr[0]),
        .mem_read_data(mem_read_data[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
        .out_ready(out_ready[0]), .out_last(out_last[0]), .busy(busy[0]), .done(done[0])
    );

    systolic_seq_ctrl #(.COMPUTE_CYCLES(1)) u_c1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .pe_clear(pe_clear[1]), .feed_en(feed_en[1]),
        .feed_cycle(feed_cycle[1]), .mem_w_en(mem_w_en[1]), .mem_read_addr(mem_read_addr[1]),
        .mem_read_data(mem_read_data[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
        .out_ready(out_ready[1]), .out_last(out_last[1]), .busy(busy[1]), .done(done[1])
    );

    // Registered output memory holding 0x1000+i at address i.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            mem_read_data[d] <= 16'h1000 + {11'd0, mem_read_addr[d]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        chk({tag, "_pe_clear"}, 32'(pe_clear[d]), 0);
        chk({tag, "_feed_en"}, 32'(feed_en[d]), 0);
        chk({tag, "_feed_cycle"}, 32'(feed_cycle[d]), 0);
        chk({tag, "_mem_w_en"}, 32'(mem_w_en[d]), 0);
        chk({tag, "_addr"}, 32'(mem_read_addr[d]), 0);
        chk({tag, "_out_valid"}, 32'(out_valid[d]), 0);
        chk({tag, "_out_data"}, 32'(out_data[d]), 0);
        chk({tag, "_out_last"}, 32'(out_last[d]), 0);
        chk({tag, "_busy"}, 32'(busy[d]), 0);
        chk({tag, "_done"}, 32'(done[d]), 0);
    endtask

    // One job on instance d with C=c. Optional stall of n cycles on word s, optional start
    // re-pulses in COMPUTE and DONE, optional reset at cycle abort_t.
    task automatic job(input int d, input int c, input int s, input int n,
                       input bit repulse, input int abort_t);
        int base, done_t, hs, wen, r, v, k;
        bit in_dr, ph_out, stall;
        base   = c + 3;
        done_t = c + 35 + ((s >= 0) ? n : 0);
        hs = 0;
        wen = 0;
        sb.delete();
        for (int i = 0; i < 16; i++) sb.push_back(16'h1000 + 16'(i));
        start[d] = 1'b1;
        step();
        start[d] = 1'b0;
        for (int t = 1; t <= done_t + 2; t++) begin
            if (t > 1) step();
            cur_t = t;
            r = t - base;
            if (s >= 0 && r > 2 * s + 1) v = (r <= 2 * s + 1 + n) ? 2 * s + 1 : r - n;
            else v = r;
            k      = v / 2;
            in_dr  = (t >= base) && (t < done_t);
            ph_out = in_dr && (v % 2 == 1);
            stall  = (s >= 0) && (r >= 2 * s + 1) && (r < 2 * s + 1 + n);
            out_ready[d] = !stall;
            start[d]     = repulse && (t == 5 || t == done_t);

            chk("pe_clear", 32'(pe_clear[d]), 32'(t == 1));
            chk("feed_en", 32'(feed_en[d]), 32'(t >= 2 && t <= c + 1));
            chk("feed_cycle", 32'(feed_cycle[d]), (t >= 2 && t <= c + 1) ? 32'(t - 2) : 0);
            chk("mem_w_en", 32'(mem_w_en[d]), 32'(t == c + 2));
            chk("addr", 32'(mem_read_addr[d]), in_dr ? 32'(k) : 0);
            chk("out_valid", 32'(out_valid[d]), 32'(ph_out));
            chk("out_data", 32'(out_data[d]), ph_out ? 32'h1000 + 32'(k) : 0);
            chk("out_last", 32'(out_last[d]), 32'(ph_out && k == 15));
            chk("done", 32'(done[d]), 32'(t == done_t));
            chk("busy", 32'(busy[d]), 32'(t <= done_t));
            if (mem_w_en[d]) wen++;

            if (t == abort_t) begin
                rst[d] = 1'b1;
                step();
                rst[d] = 1'b0;
                start[d] = 1'b0;
                out_ready[d] = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    cur_t = t + 1 + j;
                    check_idle(d, "after_rst");
                    step();
                end
                return;
            end

            if (out_valid[d] && out_ready[d]) begin
                hs++;
                chk("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) chk("sb_word", 32'(out_data[d]), 32'(sb.pop_front()));
            end
        end
        start[d] = 1'b0;
        out_ready[d] = 1'b1;
        chk("handshakes", 32'(hs), 16);
        chk("mem_w_en_pulses", 32'(wen), 1);
        chk("sb_drained", 32'(sb.size()), 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            start[d] = 1'b0;
            out_ready[d] = 1'b1;
        end
        step();
        step();
        check_idle(0, "reset_c10");
        check_idle(1, "reset_c1");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();

        job(0, 10, -1, 0, 1'b0, -1);
        job(0, 10, 3, 5, 1'b0, -1);
        job(0, 10, -1, 0, 1'b1, -1);
        job(0, 10, -1, 0, 1'b0, 5);
        job(0, 10, -1, 0, 1'b0, -1);
        job(0, 10, -1, 0, 1'b0, 28);
        job(0, 10, -1, 0, 1'b0, -1);
        job(1, 1, -1, 0, 1'b0, -1);
        job(1, 1, 15, 2, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 SHALL have parameter COMPUTE_CYCLES, default 10, number of PE-array compute cycles (legal 1..255; 10 = 3N-2 for N=4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin one matrix-multiply job; sampled only in IDLE.
REQ-005 SHALL have port pe_clear  output  1  clear PE accumulators.
REQ-006 SHALL have port feed_en  output  1  enable operand skew feeders.
REQ-007 SHALL have port feed_cycle  output  8  current compute-cycle index.
REQ-008 SHALL have port mem_w_en  output  1  capture strobe to output memory (16 PE results written in parallel).
REQ-009 SHALL have port mem_read_addr  output  5  output memory read address.
REQ-010 SHALL have port mem_read_data  input  16  output memory read data; registered, valid 1 cycle after address.
REQ-011 SHALL have port out_valid  output  1  result word available.
REQ-012 SHALL have port out_data  output  16  result word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts word.
REQ-014 SHALL have port out_last  output  1  current word is index 15.
REQ-015 SHALL have port busy  output  1  job in progress.
REQ-016 SHALL have port done  output  1  one-cycle job-complete pulse.

Function
REQ-017 SHALL implement states IDLE, CLEAR, COMPUTE, CAPTURE, DRAIN_ADDR, DRAIN_OUT, DONE; encoding free.
REQ-018 IDLE: start=1 -> CLEAR; else stay; start outside IDLE SHALL be ignored (no queuing).
REQ-019 CLEAR: exactly 1 cycle, pe_clear=1, -> COMPUTE with cycle counter = 0.
REQ-020 COMPUTE: feed_en=1, feed_cycle = counter (0..COMPUTE_CYCLES-1), counter +1 per cycle; at counter = COMPUTE_CYCLES-1 -> CAPTURE.
REQ-021 CAPTURE: exactly 1 cycle, mem_w_en=1, word index idx (4 bits) = 0, -> DRAIN_ADDR.
REQ-022 DRAIN_ADDR: mem_read_addr = {0, idx}, out_valid=0, 1 cycle, -> DRAIN_OUT.
REQ-023 DRAIN_OUT: mem_read_addr held = {0, idx}; out_valid=1; out_data = mem_read_data (combinational pass-through); out_last = (idx==15).
REQ-024 DRAIN_OUT with out_ready=0: hold state, idx, out_data stable (valid SHALL NOT drop until accepted).
REQ-025 DRAIN_OUT with out_ready=1: idx=15 -> DONE; else idx+1, -> DRAIN_ADDR.
REQ-026 DONE: exactly 1 cycle, done=1, -> IDLE; start in DONE ignored.
REQ-027 busy = 1 in every state except IDLE.
REQ-028 Outside their states pe_clear, feed_en, mem_w_en, out_valid, out_last, done SHALL be 0; feed_cycle, mem_read_addr, out_data SHALL be 0.
REQ-029 Timing with start sampled at cycle 0 and out_ready=1: CLEAR cycle 1; COMPUTE cycles 2..C+1; CAPTURE C+2; word k presented cycle C+4+2k; done cycle C+35 (C=COMPUTE_CYCLES).
REQ-030 Exactly one mem_w_en pulse and exactly 16 handshakes (indices 0..15 in order) per job; idx SHALL NOT wrap past 15.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, counter=0, idx=0 and all outputs 0 next cycle, from any state (including mid-COMPUTE or mid-DRAIN); rst has priority over start.
REQ-032 After rst deasserts, no job SHALL start without a new start pulse.

Verification
REQ-033 C=10, start pulse cycle 0, out_ready=1, mem model with mem[i]=0x1000+i -> pe_clear cycle 1, feed_cycle 0..9 cycles 2..11, mem_w_en cycle 12, out_data 0x1000..0x100F at cycles 14,16,..,44, out_last cycle 44 only, done cycle 45.
REQ-034 Backpressure: out_ready=0 for 5 cycles on word 3 -> out_valid held, out_data 0x1003 stable, mem_read_addr=3; stream resumes in order, done delayed by 5 cycles.
REQ-035 start re-pulsed during COMPUTE and in DONE -> ignored; exactly one mem_w_en and 16 words; busy returns 0 after done.
REQ-036 rst asserted at cycle 5 (mid-COMPUTE) and again during DRAIN_OUT word 7 -> next cycle all outputs 0, busy=0; fresh start yields full job from word 0.
REQ-037 COMPUTE_CYCLES=1 -> exactly one feed_en cycle with feed_cycle=0; mem_w_en cycle 3; done cycle 36.
